sbus_frame_ctrl: RTL

SBUS_FRAME_CTRL -- requirements
Module: sbus_frame_ctrl

---
 rtl/sbus_frame_ctrl_pkg.sv | 20 ++
 rtl/sbus_frame_ctrl_unpack.sv | 82 ++++++++
 rtl/sbus_frame_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sbus_frame_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the S.BUS frame decoder.
package sbus_frame_ctrl_pkg;

    localparam logic [7:0] SBUS_HEADER      = 8'h0F;
    localparam int         SBUS_FRAME_BYTES = 25;
    localparam int         SBUS_NUM_CH      = 16;
    localparam int         SBUS_CH_BITS     = 11;
    localparam int         SBUS_DATA_BYTES  = 23;
    localparam int         SBUS_SHADOW_BITS = SBUS_DATA_BYTES * 8;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } sbus_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sbus_frame_ctrl_unpack.sv
// Shadow register and channel sequencer: emits one 11-bit channel per cycle,
// then a frame strobe carrying the flag nibble.
module sbus_unpack
    import sbus_frame_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SBUS_SHADOW_BITS-1:0] frame_bits_i,
    output logic                        busy_o,
    output logic                        ch_valid_o,
    output logic [3:0]                  ch_idx_o,
    output logic [SBUS_CH_BITS-1:0]     ch_data_o,
    output logic                        frame_valid_o,
    output logic [3:0]                  flags_o
);

    logic [SBUS_SHADOW_BITS-1:0] shadow_q;
    logic [4:0]                  cnt_q;
    logic                        active_q;
    logic                        ch_valid_q;
    logic [3:0]                  ch_idx_q;
    logic [SBUS_CH_BITS-1:0]     ch_data_q;
    logic                        frame_valid_q;
    logic [3:0]                  flags_q;

    logic last_step;
    assign last_step = (cnt_q == 5'(SBUS_NUM_CH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            active_q      <= 1'b0;
            cnt_q         <= '0;
            ch_valid_q    <= 1'b0;
            ch_idx_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            flags_q       <= '0;
        end else begin
            ch_valid_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            if (start_i) begin
                // Channel 0 is emitted straight from the incoming frame so it lands one cycle after the footer.
                active_q   <= 1'b1;
                cnt_q      <= 5'd1;
                ch_valid_q <= 1'b1;
                ch_idx_q   <= '0;
                ch_data_q  <= frame_bits_i[SBUS_CH_BITS-1:0];
            end else if (active_q) begin
                if (last_step) begin
                    active_q      <= 1'b0;
                    cnt_q         <= '0;
                    frame_valid_q <= 1'b1;
                    flags_q       <= shadow_q[3:0];
                end else begin
                    ch_valid_q <= 1'b1;
                    ch_idx_q   <= cnt_q[3:0];
                    ch_data_q  <= shadow_q[SBUS_CH_BITS-1:0];
                    cnt_q      <= cnt_q + 5'd1;
                end
            end
        end
    end

    // NOTE: pure data storage is left out of reset; control state alone decides when it is meaningful.
    always_ff @(posedge clk) begin
        if (start_i) begin
            shadow_q <= frame_bits_i >> SBUS_CH_BITS;
        end else if (active_q && !last_step) begin
            shadow_q <= shadow_q >> SBUS_CH_BITS;
        end
    end

    assign busy_o        = active_q;
    assign ch_valid_o    = ch_valid_q;
    assign ch_idx_o      = ch_idx_q;
    assign ch_data_o     = ch_data_q;
    assign frame_valid_o = frame_valid_q;
    assign flags_o       = flags_q;

endmodule

// File: rtl/sbus_frame_ctrl.sv
// S.BUS frame controller: hunts for the header, collects 25 bytes under a
// gap timeout, validates the footer and hands the payload to the unpacker.
module sbus_frame_ctrl
    import sbus_frame_ctrl_pkg::*;
#(
    parameter int         PAYLOAD_BITS = 8,
    parameter int         GAP_CYCLES   = 25000,
    parameter logic [7:0] FOOTER       = 8'h00
) (
    input  logic                    clk,
    input  logic                    sw_0,
    input  logic                    en,
    input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
    input  logic                    uart_rx_valid,
    input  logic                    uart_rx_break,
    output logic                    ch_valid,
    output logic [3:0]              ch_idx,
    output logic [10:0]             ch_data,
    output logic                    frame_valid,
    output logic [3:0]              flags,
    output logic [7:0]              frame_err_cnt,
    output logic                    busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    sbus_state_e                 state_q;
    logic [4:0]                  idx_q;
    logic [GAP_W-1:0]            gap_q;
    logic [7:0]                  err_q;
    logic [7:0]                  buf_q [SBUS_DATA_BYTES];
    logic [SBUS_SHADOW_BITS-1:0] frame_bits;

    logic [7:0] rx_byte;
    logic       byte_fire;
    logic       in_collect;
    logic       last_idx;
    logic       start;
    logic       unpack_busy;

    assign rx_byte    = 8'(uart_rx_data);
    assign byte_fire  = uart_rx_valid && !uart_rx_break;
    assign in_collect = (state_q == ST_COLLECT);
    assign last_idx   = (idx_q == 5'(SBUS_FRAME_BYTES - 1));
    assign start      = in_collect && en && byte_fire && last_idx && (rx_byte == FOOTER);

    always_ff @(posedge clk) begin
        if (sw_0) begin
            state_q <= ST_HUNT;
            idx_q   <= '0;
            gap_q   <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (en && byte_fire && rx_byte == SBUS_HEADER) begin
                        state_q <= ST_COLLECT;
                        idx_q   <= 5'd1;
                        gap_q   <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (!en) begin
                        state_q <= ST_HUNT;
                        idx_q   <= '0;
                        gap_q   <= '0;
                    end else if (uart_rx_break) begin
                        state_q <= ST_HUNT;
                        idx_q   <= '0;
                        gap_q   <= '0;
                        err_q   <= sat_inc8(err_q);
                    end else if (uart_rx_valid) begin
                        gap_q <= '0;
                        if (last_idx) begin
                            state_q <= ST_HUNT;
                            idx_q   <= '0;
                            if (rx_byte != FOOTER) begin
                                err_q <= sat_inc8(err_q);
                            end
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        // The timeout edge lands exactly GAP_CYCLES edges after the last accepted byte.
                        state_q <= ST_HUNT;
                        idx_q   <= '0;
                        gap_q   <= '0;
                        err_q   <= sat_inc8(err_q);
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_collect && en && byte_fire && !last_idx) begin
            buf_q[idx_q - 5'd1] <= rx_byte;
        end
    end

    // Byte j+1 of the frame occupies frame bits [8j+7:8j], LSB first.
    for (genvar j = 0; j < SBUS_DATA_BYTES; j++) begin : g_flat
        assign frame_bits[8*j +: 8] = buf_q[j];
    end

    sbus_unpack u_unpack (
        .clk           (clk),
        .rst_i         (sw_0),
        .start_i       (start),
        .frame_bits_i  (frame_bits),
        .busy_o        (unpack_busy),
        .ch_valid_o    (ch_valid),
        .ch_idx_o      (ch_idx),
        .ch_data_o     (ch_data),
        .frame_valid_o (frame_valid),
        .flags_o       (flags)
    );

    assign frame_err_cnt = err_q;
    assign busy          = in_collect || unpack_busy;

endmodule
